joypad_matrix: RTL and testbench
================================

JOYPAD_MATRIX -- requirements
Module: joypad_matrix

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1024: consecutive clk cycles a synchronized button level must differ from its stable state before the stable state changes; legal range 1..65535.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 btn_raw  input  8  raw button levels, 1 = pressed, asynchronous to clk; bit 0 Right, 1 Left, 2 Up, 3 Down, 4 A, 5 B, 6 Select, 7 Start.
REQ-005 sel  input  2  P1 select lines, active-low; bit 0 = P14 (direction group), bit 1 = P15 (action group); driven from JOYPAD register bits 4 and 5.
REQ-006 p1_in  output  4  P10..P13 input lines, active-low; consumed as JOYPAD register bits 3:0.
REQ-007 irq  output  1  joypad interrupt request; one-cycle high pulse.

Function
REQ-008 Each btn_raw bit SHALL pass through a two-flop synchronizer before any other use.
REQ-009 Each button SHALL keep a stable state bit and a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-010 Counter behaviour: increment when the synchronized level differs from the stable state; clear when they are equal.
REQ-011 When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ: invert the stable state on the next edge and clear the counter.
REQ-012 A level change held steady SHALL appear in the stable state exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave the stable state unchanged and clear the counter.
REQ-014 Direction group dir[3:0] = stable bits {Down, Up, Left, Right}. Action group act[3:0] = stable bits {Start, Select, B, A}.
REQ-015 p1_in[i] = NOT((sel[0]==0 AND dir[i]) OR (sel[1]==0 AND act[i])). This is combinational from the registered stable state and sel, with zero-cycle latency on sel changes.
REQ-016 With sel = 2'b11 (neither group selected), p1_in SHALL be 4'hF regardless of button state.
REQ-017 With sel = 2'b00, the groups SHALL combine by wired-AND: a line is low if either group's button on that line is pressed.
REQ-018 A registered copy p1_prev SHALL capture p1_in every cycle.
REQ-019 irq SHALL be high for exactly the one cycle after any bit has p1_prev=1 and p1_in=0 (falling edge). This applies whether the fall was caused by a button or by a sel change.
REQ-020 Multiple bits falling in the same cycle SHALL produce a single one-cycle irq pulse.
REQ-021 Rising edges of p1_in (releases) SHALL never assert irq.

Reset
REQ-022 While reset is high: synchronizer flops 0; stable states 0 (released); counters 0; p1_prev 4'hF; irq 0.
REQ-023 In reset, p1_in SHALL equal 4'hF for any sel.
REQ-024 A button already held when reset deasserts SHALL become stable DEBOUNCE_CYCLES+2 edges after deassertion and SHALL then raise irq if its group is selected.
REQ-025 Reset asserted mid-count SHALL discard the partial count.

Configuration
REQ-026 Macro JOYPAD_DEBOUNCE_EN defined: debounce per REQ-009..REQ-013.
REQ-027 Macro JOYPAD_DEBOUNCE_EN undefined:
- no counters are instantiated;
- the stable state equals the synchronizer output (latency 2 edges);
- DEBOUNCE_CYCLES is ignored;
- all other behaviour is unchanged.

Structure
REQ-028 Shared package joypad_pkg SHALL hold:
- the button index constants (BTN_RIGHT..BTN_START);
- the select-bit positions (SEL_DIR=0, SEL_ACT=1);
- the JOYPAD register address constant 16'hFF00.
REQ-029 The per-button synchronizer plus debounce SHALL be a sub-module joypad_debounce (1-bit in, 1-bit stable out), instantiated 8 times.
REQ-030 Nibble muxing and irq edge detection SHALL reside in joypad_matrix.

Verification (DEBOUNCE_CYCLES=4, JOYPAD_DEBOUNCE_EN defined unless noted)
REQ-031 Bench SHALL cover these five directed scenarios:
- Timing: sel=2'b10, raise btn_raw[0] (Right) at edge 0 and hold -> p1_in goes 4'hF to 4'hE after edge 6; irq=1 for exactly one cycle after edge 7.
- Glitch filter: sel=2'b10, btn_raw[2] (Up) high for 3 cycles then low -> p1_in stays 4'hF; irq stays 0.
- Group muxing: hold A and Down stable, then step sel 2'b11 -> 2'b01 -> 2'b10 -> 2'b00 -> p1_in = 4'hF, 4'hE, 4'h7, 4'h6; irq pulses once after each of the 2'b01, 2'b10 and 2'b00 steps.
- Reset mid-operation: sel=2'b10, assert reset while Left's count is at 2, hold Left through reset, release reset -> p1_in=4'hF until 6 edges after release, then 4'hD, followed by a single irq pulse.
- Debounce compiled out (JOYPAD_DEBOUNCE_EN undefined): sel=2'b01, press Start at edge 0 -> p1_in=4'h7 after edge 2; release -> p1_in=4'hF with no irq on the release.

Source files
------------

// File: rtl/joypad_pkg.sv
// Joypad matrix shared definitions: button indices, select bits,
// register address and the P1 nibble helper.
package joypad_pkg;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_SELECT = 6;
  localparam int BTN_START  = 7;

  localparam int SEL_DIR = 0;
  localparam int SEL_ACT = 1;

  localparam logic [15:0] JOYPAD_ADDR = 16'hFF00;

  typedef struct packed {
    logic [3:0] act;
    logic [3:0] dir;
  } groups_t;

  // Active-low wired-AND of whichever groups are selected.
  function automatic logic [3:0] p1_drive(
    input logic [1:0] sel,
    input groups_t    g
  );
    logic [3:0] dir_m;
    logic [3:0] act_m;
    dir_m = sel[SEL_DIR] ? 4'h0 : g.dir;
    act_m = sel[SEL_ACT] ? 4'h0 : g.act;
    return ~(dir_m | act_m);
  endfunction

endpackage

// File: rtl/joypad_if.sv
// Joypad bus: raw buttons and P1 select in, P1 lines and
// interrupt request out.
interface joypad_if;
  logic [7:0] btn_raw;
  logic [1:0] sel;
  logic [3:0] p1_in;
  logic       irq;

  modport master (
    output btn_raw,
    output sel,
    input  p1_in,
    input  irq
  );

  modport slave (
    input  btn_raw,
    input  sel,
    output p1_in,
    output irq
  );
endinterface

// File: rtl/joypad_debounce.sv
// Per-button two-flop synchronizer plus counter debounce.
// Debounce present only with JOYPAD_DEBOUNCE_EN defined.
module joypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic stable_o
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES out of range 1..65535");
  end

  logic [1:0] sync_q;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], btn_i};
  end

`ifdef JOYPAD_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          stable_q;
  logic          stable_d;

  // Count while the level disagrees; flip after a full run.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = ~stable_q;
      else                   cnt_d    = cnt_q + 1'b1;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  assign stable_o = sync_q[1];
`endif

endmodule

// File: rtl/joypad_matrix.sv
// Joypad P1 matrix: debounced buttons, group mux, falling-edge irq.
// Optional debounce controlled by JOYPAD_DEBOUNCE_EN.
import joypad_pkg::*;

module joypad_matrix #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic     clk,
  input  logic     reset,
  joypad_if.slave  bus
);

  logic [7:0] stable_w;
  groups_t    grp_w;
  logic [3:0] p1_w;
  logic [3:0] p1_prev_q;
  logic       irq_q;
  logic       irq_d;

  for (genvar i = 0; i < 8; i++) begin : g_btn
    joypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (bus.btn_raw[i]),
      .stable_o (stable_w[i])
    );
  end

  assign grp_w.dir = {stable_w[BTN_DOWN], stable_w[BTN_UP],
                      stable_w[BTN_LEFT], stable_w[BTN_RIGHT]};
  assign grp_w.act = {stable_w[BTN_START], stable_w[BTN_SELECT],
                      stable_w[BTN_B], stable_w[BTN_A]};

  assign p1_w = p1_drive(bus.sel, grp_w);

  // Any line going 1 -> 0 requests an interrupt.
  always_comb begin
    irq_d = |(p1_prev_q & ~p1_w);
  end

  // Previous P1 lines and the registered irq pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_prev_q <= 4'hF;
      irq_q     <= 1'b0;
    end else begin
      p1_prev_q <= p1_w;
      irq_q     <= irq_d;
    end
  end

  assign bus.p1_in = p1_w;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_joypad_matrix.sv
// Self-checking bench for joypad_matrix, DEBOUNCE_CYCLES=4.
// Expectations adapt to JOYPAD_DEBOUNCE_EN.
module tb_joypad_matrix;

  localparam int DB = 4;
`ifdef JOYPAD_DEBOUNCE_EN
  localparam int LAT = DB + 2;
  localparam bit DBEN = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit DBEN = 1'b0;
`endif

  typedef struct {
    logic [3:0] p1;
    logic       irq;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  joypad_if bus ();

  joypad_matrix #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    exp_t e;
    logic [1:0] s;
    reset = 1'b1;
    bus.btn_raw = 8'h00;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      bus.sel = s;
      e.p1 = 4'hF; e.irq = 1'b0;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL reset sel=%b p1_in=%h irq=%b want %h %b",
                 s, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
    bus.sel = 2'b10;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      e.p1 = 4'hF; e.irq = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL idle k=%0d p1_in=%h irq=%b want %h %b",
                 k, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
  endtask

  task automatic test_press(
    input string      tag,
    input logic [7:0] btn,
    input logic [1:0] s,
    input logic [3:0] nib
  );
    exp_t e;
    bus.sel = s;
    bus.btn_raw = btn;
    for (int k = 1; k <= LAT + 3; k++) begin
      e.p1  = (k >= LAT) ? nib : 4'hF;
      e.irq = (k == LAT + 1);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL %s press k=%0d p1_in=%h irq=%b want %h %b",
                 tag, k, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
    bus.btn_raw = 8'h00;
    for (int k = 1; k <= LAT + 3; k++) begin
      e.p1  = (k >= LAT) ? 4'hF : nib;
      e.irq = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL %s release k=%0d p1_in=%h irq=%b want %h %b",
                 tag, k, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    bus.sel = 2'b10;
    bus.btn_raw = 8'h04;
    for (int k = 1; k <= 10; k++) begin
      if (DBEN) begin
        e.p1  = 4'hF;
        e.irq = 1'b0;
      end else begin
        e.p1  = (k >= 2 && k <= 4) ? 4'hB : 4'hF;
        e.irq = (k == 3);
      end
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL glitch k=%0d p1_in=%h irq=%b want %h %b",
                 k, bus.p1_in, bus.irq, e.p1, e.irq);
      end
      if (k == 3) bus.btn_raw = 8'h00;
    end
  endtask

  task automatic test_group_mux();
    exp_t e;
    logic [1:0] steps [3];
    logic [3:0] nibs [3];
    steps = '{2'b01, 2'b10, 2'b00};
    nibs  = '{4'hE, 4'h7, 4'h6};
    bus.sel = 2'b11;
    bus.btn_raw = 8'h18;
    for (int k = 1; k <= LAT + 2; k++) begin
      e.p1 = 4'hF; e.irq = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL mux settle k=%0d p1_in=%h irq=%b want %h %b",
                 k, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
    for (int i = 0; i < 3; i++) begin
      bus.sel = steps[i];
      for (int c = 0; c < 3; c++) begin
        e.p1  = nibs[i];
        e.irq = (c == 1);
        sb.push_back(e);
        if (c == 0) #1;
        else        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
          n_fail++;
          $display("FAIL mux sel=%b c=%0d p1_in=%h irq=%b want %h %b",
                   steps[i], c, bus.p1_in, bus.irq, e.p1, e.irq);
        end
      end
    end
    bus.sel = 2'b11;
    bus.btn_raw = 8'h00;
    for (int k = 1; k <= LAT + 2; k++) begin
      e.p1 = 4'hF; e.irq = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL mux release k=%0d p1_in=%h irq=%b want %h %b",
                 k, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [1:0] rs [3];
    rs = '{2'b00, 2'b01, 2'b11};
    bus.sel = 2'b10;
    bus.btn_raw = 8'h02;
    for (int k = 1; k <= 4; k++) begin
      e.p1  = (k >= LAT) ? 4'hD : 4'hF;
      e.irq = (k == LAT + 1);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL rst pre k=%0d p1_in=%h irq=%b want %h %b",
                 k, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) bus.sel = rs[i];
      e.p1 = 4'hF; e.irq = 1'b0;
      sb.push_back(e);
      if (i < 3) #1;
      else       @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL rst hold i=%0d p1_in=%h irq=%b want %h %b",
                 i, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
    bus.sel = 2'b10;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= LAT + 3; k++) begin
      e.p1  = (k >= LAT) ? 4'hD : 4'hF;
      e.irq = (k == LAT + 1);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL rst post k=%0d p1_in=%h irq=%b want %h %b",
                 k, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
    bus.btn_raw = 8'h00;
    for (int k = 1; k <= LAT + 2; k++) begin
      e.p1  = (k >= LAT) ? 4'hF : 4'hD;
      e.irq = 1'b0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.p1_in !== e.p1 || bus.irq !== e.irq) begin
        n_fail++;
        $display("FAIL rst release k=%0d p1_in=%h irq=%b want %h %b",
                 k, bus.p1_in, bus.irq, e.p1, e.irq);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_press("right", 8'h01, 2'b10, 4'hE);
    test_glitch();
    test_press("start", 8'h80, 2'b01, 4'h7);
    test_group_mux();
    test_reset_mid();
    test_press("multi", 8'h03, 2'b10, 4'hC);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
